// File: rtl/controlador_exibicao.sv
// Plays back a stored LED sequence: each step reads a pattern from memory, lights it,
// blanks it, then advances, with a fast mode that halves both intervals.
module controlador_exibicao #(
    parameter int unsigned TEMPO_ACESO   = 1000,
    parameter int unsigned TEMPO_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic       dificuldade,
    input  logic [3:0] tamanho,
    input  logic [7:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [7:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned TMAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ULT_ACESO_NORMAL   = TW'(TEMPO_ACESO - 1);
    localparam logic [TW-1:0] ULT_ACESO_RAPIDO   = TW'(TEMPO_ACESO / 2 - 1);
    localparam logic [TW-1:0] ULT_APAGADO_NORMAL = TW'(TEMPO_APAGADO - 1);
    localparam logic [TW-1:0] ULT_APAGADO_RAPIDO = TW'(TEMPO_APAGADO / 2 - 1);

    typedef enum logic [3:0] {
        Inicial = 4'd0,
        Prepara = 4'd1,
        Acende  = 4'd2,
        Apaga   = 4'd3,
        Proximo = 4'd4,
        Fim     = 4'd5
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    leds_d;
    logic          dif_q, dif_d;
    logic [3:0]    tam_q, tam_d;
    logic [TW-1:0] ult_aceso, ult_apagado;

    assign ult_aceso   = dif_q ? ULT_ACESO_RAPIDO : ULT_ACESO_NORMAL;
    assign ult_apagado = dif_q ? ULT_APAGADO_RAPIDO : ULT_APAGADO_NORMAL;

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        timer_d    = '0;
        leds_d     = leds;
        dif_d      = dif_q;
        tam_d      = tam_q;
        if (reset) begin
            estado_d   = Inicial;
            endereco_d = '0;
            leds_d     = '0;
        end else if (cancelar && (estado_q != Inicial)) begin
            estado_d   = Inicial;
            endereco_d = '0;
            leds_d     = '0;
        end else begin
            case (estado_q)
                Inicial: begin
                    if (iniciar) begin
                        dif_d      = dificuldade;
                        tam_d      = tamanho;
                        endereco_d = '0;
                        estado_d   = (tamanho == 4'd0) ? Fim : Prepara;
                    end
                end
                Prepara: begin
                    leds_d   = dado_memoria;
                    estado_d = Acende;
                end
                Acende: begin
                    if (timer_q == ult_aceso) begin
                        leds_d   = '0;
                        estado_d = Apaga;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                Apaga: begin
                    if (timer_q == ult_apagado) begin
                        estado_d = Proximo;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                Proximo: begin
                    if (endereco_q == tam_q - 4'd1) begin
                        estado_d = Fim;
                    end else begin
                        endereco_d = endereco_q + 4'd1;
                        estado_d   = Prepara;
                    end
                end
                Fim: begin
                    endereco_d = '0;
                    estado_d   = Inicial;
                end
                default: begin
                    endereco_d = '0;
                    leds_d     = '0;
                    estado_d   = Inicial;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= Inicial;
            endereco_q <= '0;
            timer_q    <= '0;
            leds       <= '0;
            dif_q      <= 1'b0;
            tam_q      <= '0;
            pronto     <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            timer_q    <= timer_d;
            leds       <= leds_d;
            dif_q      <= dif_d;
            tam_q      <= tam_d;
            pronto     <= (estado_d == Fim);
            ocupado    <= (estado_d != Inicial);
        end
    end

    // The memory read has one cycle of latency, so it is fed the next-cycle address; the
    // pattern for the current address is then ready while PREPARA is active.
    assign endereco  = endereco_d;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_controlador_exibicao.sv
// Randomized playback scenarios checked cycle by cycle against an arithmetic timeline model.
module tb_controlador_exibicao;

    localparam int TA = 4;
    localparam int TP = 2;

    logic       clock = 1'b0;
    logic       reset, iniciar, cancelar, dificuldade;
    logic [3:0] tamanho;
    logic [7:0] dado_memoria;
    logic [3:0] endereco;
    logic [7:0] leds;
    logic       ocupado, pronto;
    logic [3:0] db_estado;

    logic [7:0] mem [16];
    int errors = 0;
    int checks = 0;

    controlador_exibicao #(
        .TEMPO_ACESO   (TA),
        .TEMPO_APAGADO (TP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .cancelar     (cancelar),
        .dificuldade  (dificuldade),
        .tamanho      (tamanho),
        .dado_memoria (dado_memoria),
        .endereco     (endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) dado_memoria <= mem[endereco];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs in cycle rel after a start sampled at rel=0.
    // Each step: 1 read cycle, ton lit, toff dark, 1 advance cycle; completion follows the last step.
    function automatic void model(input int rel, input int n, input bit dif,
                                  output logic [7:0] e_leds, output logic e_pronto,
                                  output logic e_ocup, output logic [3:0] e_est,
                                  output int e_addr);
        int ton, toff, p, k, ph;
        ton  = dif ? TA / 2 : TA;
        toff = dif ? TP / 2 : TP;
        p    = ton + toff + 2;
        e_leds = 8'h00; e_pronto = 1'b0; e_ocup = 1'b0; e_est = 4'd0; e_addr = 0;
        if (rel >= 1 && rel <= n * p) begin
            k  = (rel - 1) / p;
            ph = (rel - 1) % p;
            e_ocup = 1'b1;
            e_addr = k;
            if (ph == 0) begin
                e_est = 4'd1;
            end else if (ph <= ton) begin
                e_est  = 4'd2;
                e_leds = mem[k];
            end else if (ph <= ton + toff) begin
                e_est = 4'd3;
            end else begin
                e_est  = 4'd4;
                e_addr = -1;
            end
        end else if (rel == n * p + 1) begin
            e_pronto = 1'b1;
            e_ocup   = 1'b1;
            e_est    = 4'd5;
        end
    endfunction

    // abort_at > 0 asserts cancelar (or reset when use_reset) during that cycle.
    task automatic play(input int n, input bit dif, input int abort_at, input bit use_reset,
                        input bit disturb, input string tag);
        logic [7:0] e_leds;
        logic       e_pronto, e_ocup;
        logic [3:0] e_est;
        int         e_addr, p, total;
        p = (dif ? (TA + TP) / 2 : TA + TP) + 2;
        total = n * p + 4;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(1, 255));
        dificuldade = dif;
        tamanho     = 4'(n);
        iniciar     = 1'b1;
        cancelar    = 1'b0;
        reset       = 1'b0;
        for (int rel = 1; rel <= total; rel++) begin
            tick();
            if (abort_at > 0 && rel > abort_at)
                model(-1, n, dif, e_leds, e_pronto, e_ocup, e_est, e_addr);
            else
                model(rel, n, dif, e_leds, e_pronto, e_ocup, e_est, e_addr);
            checks += 5;
            if (leds !== e_leds) begin
                errors++;
                $display("FAIL %s leds cycle %0d: got %h want %h", tag, rel, leds, e_leds);
            end
            if (pronto !== e_pronto) begin
                errors++;
                $display("FAIL %s pronto cycle %0d: got %b want %b", tag, rel, pronto, e_pronto);
            end
            if (ocupado !== e_ocup) begin
                errors++;
                $display("FAIL %s ocupado cycle %0d: got %b want %b", tag, rel, ocupado, e_ocup);
            end
            if (db_estado !== e_est) begin
                errors++;
                $display("FAIL %s db_estado cycle %0d: got %0d want %0d", tag, rel, db_estado, e_est);
            end
            if (e_addr >= 0 && endereco !== 4'(e_addr)) begin
                errors++;
                $display("FAIL %s endereco cycle %0d: got %0d want %0d", tag, rel, endereco, e_addr);
            end
            iniciar  = 1'b0;
            cancelar = 1'b0;
            reset    = 1'b0;
            if (disturb && rel < n * p - 2) begin
                dificuldade = 1'($urandom);
                tamanho     = 4'($urandom);
                if (rel == 3) iniciar = 1'b1;
            end
            if (rel == abort_at) begin
                if (use_reset) reset = 1'b1;
                else cancelar = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b1; cancelar = 1'b0; dificuldade = 1'b0; tamanho = 4'd3;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks += 4;
            if (db_estado !== 4'd0) begin
                errors++;
                $display("FAIL reset db_estado: got %0d want 0", db_estado);
            end
            if (leds !== 8'h00 || endereco !== 4'd0) begin
                errors++;
                $display("FAIL reset leds/endereco: got %h/%0d want 00/0", leds, endereco);
            end
            if (ocupado !== 1'b0) begin
                errors++;
                $display("FAIL reset ocupado: got %b want 0", ocupado);
            end
            if (pronto !== 1'b0) begin
                errors++;
                $display("FAIL reset pronto: got %b want 0", pronto);
            end
        end
        reset = 1'b0; iniciar = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        play(3, 1'b0, 0, 1'b0, 1'b0, "normal");
    endtask

    task automatic test_fast();
        play(3, 1'b1, 0, 1'b0, 1'b0, "fast");
    endtask

    task automatic test_zero_length();
        play(0, 1'b0, 0, 1'b0, 1'b0, "zero");
        play(0, 1'b1, 0, 1'b0, 1'b0, "zero_fast");
    endtask

    task automatic test_cancel();
        play(3, 1'b0, 10, 1'b0, 1'b0, "cancel");
        play(2, 1'b0, 0, 1'b0, 1'b0, "restart");
    endtask

    task automatic test_reset_mid();
        play(3, 1'b0, 4, 1'b1, 1'b0, "reset_mid");
        play(3, 1'b0, 0, 1'b0, 1'b1, "iniciar_mid");
    endtask

    task automatic test_disturb();
        play(4, 1'b1, 0, 1'b0, 1'b1, "disturb_fast");
        play(15, 1'b0, 0, 1'b0, 1'b1, "disturb_max");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            int  n;
            bit  d;
            n = $urandom_range(0, 6);
            d = 1'($urandom);
            if (n > 0 && $urandom_range(0, 2) == 0)
                play(n, d, $urandom_range(1, n * 4), 1'($urandom), 1'b0, "random_abort");
            else
                play(n, d, 0, 1'b0, 1'($urandom), "random");
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; cancelar = 1'b0; dificuldade = 1'b0; tamanho = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_normal();
        test_fast();
        test_zero_length();
        test_cancel();
        test_reset_mid();
        test_disturb();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
